fetch_stage: RTL and testbench

//  IF stage plus IF/ID pipeline register; directly upstream of decode_stage.

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register; req/gnt/rvalid imem port, one request outstanding. Optional FETCH_PERF_EN adds fetch/bubble counters.
// Latency: 1 cycle from rvalid to IF/ID; peak one instruction per 2 cycles (REQ then WAIT).
// Backpressure: stall_signal freezes IF/ID and fetch_pc; a response arriving under stall parks in a hold buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_signal,
    input  logic        pcsrc,
    input  logic [31:0] branched_PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_code,
    output logic [31:0] PC,
    output logic        if_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, req_pc, buf_dat, buf_pc;
    logic        drop;

    logic        rsp, accept, load_wait, load_hold, load, to_hold;
    logic [31:0] load_dat, load_pc, redirect_pc;

    assign rsp       = (state == WAIT) && imem_rvalid;
    assign accept    = rsp && !drop && !pcsrc;
    assign load_wait = accept && !stall_signal;
    assign to_hold   = accept && stall_signal;
    assign load_hold = (state == HOLD) && !stall_signal && !pcsrc;
    assign load      = load_wait || load_hold;
    assign load_dat  = load_hold ? buf_dat : imem_rdata;
    assign load_pc   = load_hold ? buf_pc  : req_pc;
    assign redirect_pc = branched_PC & ~32'h3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // A response coinciding with a redirect is the one being discarded, so fetch restarts directly.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     if (imem_gnt) state_nxt = WAIT;
            WAIT:    if (rsp) state_nxt = to_hold ? HOLD : REQ;
            HOLD:    if (pcsrc || !stall_signal) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state == REQ);
        imem_addr = fetch_pc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            buf_dat  <= NOP_INSTR;
            buf_pc   <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            if (pcsrc)     fetch_pc <= redirect_pc;
            else if (load) fetch_pc <= load_pc + 32'd4;

            if (state == REQ && imem_gnt) req_pc <= fetch_pc;

            if (to_hold) begin
                buf_dat <= imem_rdata;
                buf_pc  <= req_pc;
            end

            // Exactly one in-flight response is discarded, however many redirects pile up.
            if (rsp)
                drop <= 1'b0;
            else if (pcsrc && (state == WAIT || (state == REQ && imem_gnt)))
                drop <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction_code <= NOP_INSTR;
            PC               <= RESET_PC;
            if_valid         <= 1'b0;
        end else if (pcsrc || (!stall_signal && !load)) begin
            instruction_code <= NOP_INSTR;
            if_valid         <= 1'b0;
        end else if (load) begin
            instruction_code <= load_dat;
            PC               <= load_pc;
            if_valid         <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else begin
            if (load && !pcsrc && fetch_count != 32'hFFFF_FFFF)
                fetch_count <= fetch_count + 32'd1;
            if (!if_valid && state != IDLE && bubble_count != 32'hFFFF_FFFF)
                bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: handshake, stall/hold, redirects, wrap, reset mid-fetch, perf counters.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_signal = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] branched_PC = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction_code;
    logic [31:0] PC;
    logic        if_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int errors = 0;
    int checks = 0;
    int bub_exp = 0;
    bit count_en = 1'b0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall_signal(stall_signal), .pcsrc(pcsrc),
        .branched_PC(branched_PC), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction_code(instruction_code), .PC(PC), .if_valid(if_valid)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        if (count_en && if_valid === 1'b0) bub_exp++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++; if (instruction_code !== NOP) begin errors++; $display("FAIL rst_ic got=%h exp=%h", instruction_code, NOP); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", PC); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        reset = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    endtask

    task automatic test_basic_fetch();
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_wait_req got=%b exp=0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; tick(); imem_rvalid = 1'b0;
        checks++; if (instruction_code !== 32'h0050_0093) begin errors++; $display("FAIL basic_ic got=%h exp=00500093", instruction_code); end
        checks++; if (PC !== 32'h0 || if_valid !== 1'b1) begin errors++; $display("FAIL basic_pc got=%h/%b exp=0/1", PC, if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next got=%b/%h exp=1/4", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        stall_signal = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0020_81B3; tick(); imem_rvalid = 1'b0;
        checks++; if (imem_req !== 1'b0 || instruction_code !== NOP) begin errors++; $display("FAIL stall_hold1 got=%b/%h exp=0/%h", imem_req, instruction_code, NOP); end
        tick(); tick();
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || instruction_code !== NOP) begin errors++; $display("FAIL stall_hold3 got=%b/%b/%h exp=0/0/%h", imem_req, if_valid, instruction_code, NOP); end
        stall_signal = 1'b0; tick();
        checks++; if (instruction_code !== 32'h0020_81B3 || PC !== 32'h4 || if_valid !== 1'b1) begin errors++; $display("FAIL stall_release got=%h/%h/%b exp=002081b3/4/1", instruction_code, PC, if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_next got=%b/%h exp=1/8", imem_req, imem_addr); end
    endtask

    task automatic test_flush_wait();
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        pcsrc = 1'b1; branched_PC = 32'h40; tick(); pcsrc = 1'b0;
        checks++; if (instruction_code !== NOP || if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL flush_ifid got=%h/%b/%b exp=%h/0/0", instruction_code, if_valid, imem_req, NOP); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 1'b0;
        checks++; if (instruction_code !== NOP || if_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got=%h/%b exp=%h/0", instruction_code, if_valid, NOP); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL flush_addr got=%b/%h exp=1/40", imem_req, imem_addr); end
    endtask

    task automatic test_flush_over_stall();
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        pcsrc = 1'b1; stall_signal = 1'b1; branched_PC = 32'h43; tick();
        pcsrc = 1'b0; stall_signal = 1'b0;
        checks++; if (instruction_code !== NOP || if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL fs_ifid got=%h/%b/%b exp=%h/0/0", instruction_code, if_valid, imem_req, NOP); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD; tick(); imem_rvalid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || if_valid !== 1'b0) begin errors++; $display("FAIL fs_resume got=%b/%h/%b exp=1/40/0", imem_req, imem_addr, if_valid); end
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; tick(); imem_rvalid = 1'b0;
        checks++; if (instruction_code !== 32'h1111_1111 || PC !== 32'h40 || imem_addr !== 32'h44) begin errors++; $display("FAIL fs_fetch got=%h/%h/%h exp=11111111/40/44", instruction_code, PC, imem_addr); end
    endtask

    task automatic test_wrap();
        pcsrc = 1'b1; branched_PC = 32'hFFFF_FFFE; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555; tick();
        pcsrc = 1'b0; imem_rvalid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin errors++; $display("FAIL wrap_redirect got=%b/%h/%b exp=1/fffffffc/0", imem_req, imem_addr, if_valid); end
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; tick(); imem_rvalid = 1'b0;
        checks++; if (PC !== 32'hFFFF_FFFC || instruction_code !== 32'h2222_2222 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%h/%h/%h exp=fffffffc/22222222/0", PC, instruction_code, imem_addr); end
    endtask

    task automatic test_hold_redirect();
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        stall_signal = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333; tick(); imem_rvalid = 1'b0;
        pcsrc = 1'b1; branched_PC = 32'h200; tick(); pcsrc = 1'b0; stall_signal = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0 || instruction_code !== NOP) begin errors++; $display("FAIL hold_redirect got=%b/%h/%b/%h exp=1/200/0/%h", imem_req, imem_addr, if_valid, instruction_code, NOP); end
        tick();
        checks++; if (if_valid !== 1'b0 || instruction_code !== NOP) begin errors++; $display("FAIL hold_discard got=%b/%h exp=0/%h", if_valid, instruction_code, NOP); end
    endtask

    task automatic test_reset_mid();
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++; if (instruction_code !== NOP || PC !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("FAIL rmid_ifid got=%h/%h/%b exp=%h/0/0", instruction_code, PC, if_valid, NOP); end
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_req got=%b/%h exp=0/0", imem_req, imem_addr); end
        imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
        tick(); tick();
        reset = 1'b1; tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("FAIL rmid_first got=%b/%h/%b exp=1/0/0", imem_req, imem_addr, if_valid); end
        tick();
        checks++; if (imem_req !== 1'b1 || if_valid !== 1'b0 || instruction_code !== NOP) begin errors++; $display("FAIL rmid_stale got=%b/%b/%h exp=1/0/%h", imem_req, if_valid, instruction_code, NOP); end
        imem_rvalid = 1'b0;
    endtask

`ifdef FETCH_PERF_EN
    task automatic fetch_one(input logic [31:0] d);
        int n = 0;
        while (imem_req !== 1'b1 && n < 8) begin tick(); n++; end
        if (imem_req !== 1'b1) begin errors++; checks++; $display("FAIL perf_req_timeout got=%b exp=1", imem_req); end
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = d; tick(); imem_rvalid = 1'b0;
    endtask

    task automatic test_perf();
        reset = 1'b0; tick(); reset = 1'b1;
        checks++; if (fetch_count !== 32'd0 || bubble_count !== 32'd0) begin errors++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", fetch_count, bubble_count); end
        tick();
        count_en = 1'b1; bub_exp = 0;
        for (int i = 0; i < 5; i++) fetch_one(32'h100 + i);
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        pcsrc = 1'b1; branched_PC = 32'h800; tick(); pcsrc = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; tick(); imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) fetch_one(32'h200 + i);
        count_en = 1'b0;
        checks++; if (fetch_count !== 32'd10) begin errors++; $display("FAIL perf_fetch got=%0d exp=10", fetch_count); end
        checks++; if (bubble_count !== bub_exp) begin errors++; $display("FAIL perf_bubble got=%0d exp=%0d", bubble_count, bub_exp); end
        checks++; if (PC !== 32'h810) begin errors++; $display("FAIL perf_pc got=%h exp=810", PC); end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_basic_fetch();
        test_stall();
        test_flush_wait();
        test_flush_over_stall();
        test_wrap();
        test_hold_redirect();
        test_reset_mid();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
